// File: rtl/pipe_pkg.sv
// Shared pipeline types: write-back source select, load types, datapath width default.
package pipe_pkg;

  localparam int XLEN_DFLT = 32;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_MEM = 2'd1,
    WD_PC4 = 2'd2,
    WD_IMM = 2'd3
  } wd_sel_e;

  typedef enum logic [2:0] {
    DM_LB  = 3'd0,
    DM_LH  = 3'd1,
    DM_LW  = 3'd2,
    DM_LBU = 3'd3,
    DM_LHU = 3'd4
  } dm_type_e;

endpackage

// File: rtl/load_ext.sv
// Load-data extraction: picks the addressed byte/half from a memory word and extends it.
module load_ext
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DFLT
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      offset,
  input  dm_type_e        dmType,
  output logic [XLEN-1:0] extWord
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Misaligned halves (offset 1/3) fall back to the aligned half; no trap is raised.
  assign byteSel = data[{offset, 3'b000} +: 8];
  assign halfSel = offset[1] ? data[31:16] : data[15:0];

  always_comb begin
    extWord = data;
    case (dmType)
      DM_LB:   extWord = {{(XLEN-8){byteSel[7]}}, byteSel};
      DM_LBU:  extWord = {{(XLEN-8){1'b0}}, byteSel};
      DM_LH:   extWord = {{(XLEN-16){halfSel[15]}}, halfSel};
      DM_LHU:  extWord = {{(XLEN-16){1'b0}}, halfSel};
      default: extWord = data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, source mux and load extraction driving the RF write port.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
  import pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DFLT,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_rf_wr,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_wd_sel,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_mem_rdata,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [2:0]       in_dm_type,
  input  logic [1:0]       in_addr_lo,
  output logic             rf_wr,
  output logic [4:0]       rf_wa,
  output logic [XLEN-1:0]  rf_wd,
`ifdef WB_RETIRE_CNT_EN
  output logic [CNT_W-1:0] retire_cnt,
`endif
  output logic             wb_valid
);

  logic [XLEN-1:0] extWord;
  logic [XLEN-1:0] wdNext;
  logic            rfWrNext;
  logic            loadEn;

  load_ext #(.XLEN(XLEN)) uLoadExt (
    .data    (in_mem_rdata),
    .offset  (in_addr_lo),
    .dmType  (dm_type_e'(in_dm_type)),
    .extWord (extWord)
  );

  always_comb begin
    wdNext = in_alu;
    case (wd_sel_e'(in_wd_sel))
      WD_ALU:  wdNext = in_alu;
      WD_MEM:  wdNext = extWord;
      WD_PC4:  wdNext = in_pc4;
      WD_IMM:  wdNext = in_imm;
      default: wdNext = in_alu;
    endcase
  end

  // x0 is never written, so rf_wr can never be seen with rf_wa == 0.
  assign rfWrNext = in_valid & in_rf_wr & (in_rd != 5'd0);
  assign loadEn   = ~flush & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      rf_wr    <= 1'b0;
      rf_wa    <= '0;
      rf_wd    <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      rf_wr    <= 1'b0;
      rf_wa    <= '0;
      rf_wd    <= '0;
    end else if (!stall) begin
      wb_valid <= in_valid;
      rf_wr    <= rfWrNext;
      rf_wa    <= in_rd;
      rf_wd    <= wdNext;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (loadEn && in_valid) begin
      retire_cnt <= retire_cnt + 1'b1;
    end
  end
`else
  logic unusedLoadEn;
  assign unusedLoadEn = loadEn;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; retire counter checks are active with WB_RETIRE_CNT_EN.
module tb_wb_stage;
  import pipe_pkg::*;

  localparam int XLEN = 32;
`ifdef WB_RETIRE_CNT_EN
  localparam int TB_CNT_W = 4;
`else
  localparam int TB_CNT_W = 64;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            stall, flush, in_valid, in_rf_wr;
  logic [4:0]      in_rd;
  logic [1:0]      in_wd_sel;
  logic [XLEN-1:0] in_alu, in_mem_rdata, in_pc4, in_imm;
  logic [2:0]      in_dm_type;
  logic [1:0]      in_addr_lo;
  logic            rf_wr, wb_valid;
  logic [4:0]      rf_wa;
  logic [XLEN-1:0] rf_wd;
`ifdef WB_RETIRE_CNT_EN
  logic [TB_CNT_W-1:0] retire_cnt;
`endif

  int vecCnt = 0;
  int errCnt = 0;
  logic [TB_CNT_W-1:0] expRet = '0;
  logic [XLEN-1:0] rfModel [32];

  wb_stage #(.XLEN(XLEN), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_rf_wr(in_rf_wr), .in_rd(in_rd), .in_wd_sel(in_wd_sel),
    .in_alu(in_alu), .in_mem_rdata(in_mem_rdata), .in_pc4(in_pc4), .in_imm(in_imm),
    .in_dm_type(in_dm_type), .in_addr_lo(in_addr_lo),
    .rf_wr(rf_wr), .rf_wa(rf_wa), .rf_wd(rf_wd),
`ifdef WB_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .wb_valid(wb_valid)
  );

  always #5 clk = ~clk;

  // Register file writes on the falling edge.
  always @(negedge clk) if (rf_wr) rfModel[rf_wa] <= rf_wd;

  // One rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (!rst && !stall && !flush && in_valid) expRet = expRet + 1'b1;
    #1;
  endtask

  task automatic setInstr(input logic v, input logic w, input logic [4:0] rd,
                          input logic [1:0] sel, input logic [XLEN-1:0] alu);
    in_valid = v; in_rf_wr = w; in_rd = rd; in_wd_sel = sel; in_alu = alu;
  endtask

  task automatic checkRetire(input string name);
`ifdef WB_RETIRE_CNT_EN
    vecCnt++;
    if (retire_cnt !== expRet) begin
      errCnt++; $display("FAIL %s: retire_cnt got %0d want %0d", name, retire_cnt, expRet);
    end
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 0; flush = 0;
    setInstr(1'b1, 1'b1, 5'd9, WD_ALU, 32'hCAFE_F00D);
    in_mem_rdata = 32'h80FF_7F01; in_pc4 = 32'h0000_0104; in_imm = 32'h0000_0ABC;
    in_dm_type = DM_LW; in_addr_lo = 2'd0;
    for (int i = 0; i < 32; i++) rfModel[i] = '0;
    #12;
    vecCnt++;
    if ({rf_wr, rf_wa, rf_wd, wb_valid} !== '0) begin
      errCnt++; $display("FAIL reset: wr=%b wa=%0d wd=%h valid=%b want all 0", rf_wr, rf_wa, rf_wd, wb_valid);
    end
    expRet = '0;
    checkRetire("reset_cnt");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_alu_wb();
    setInstr(1'b1, 1'b1, 5'd5, WD_ALU, 32'h1234_5678);
    step();
    vecCnt++;
    if (rf_wr !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'h1234_5678 || wb_valid !== 1'b1) begin
      errCnt++; $display("FAIL alu_wb: wr=%b wa=%0d wd=%h valid=%b want 1/5/12345678/1", rf_wr, rf_wa, rf_wd, wb_valid);
    end
    @(negedge clk); #1;
    vecCnt++;
    if (rfModel[5] !== 32'h1234_5678) begin
      errCnt++; $display("FAIL rf_x5: got %h want 12345678", rfModel[5]);
    end
    checkRetire("alu_cnt");
  endtask

  task automatic test_load_ext();
    logic [2:0]      ty  [10];
    logic [1:0]      off [10];
    logic [XLEN-1:0] exp [10];
    ty  = '{DM_LB, DM_LB, DM_LBU, DM_LH, DM_LHU, DM_LW, DM_LB, DM_LH, DM_LHU, DM_LH};
    off = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1, 2'd0};
    exp = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_80FF,
            32'h80FF_7F01, 32'h0000_0001, 32'hFFFF_80FF, 32'h0000_7F01, 32'h0000_7F01};
    in_mem_rdata = 32'h80FF_7F01;
    for (int i = 0; i < 10; i++) begin
      setInstr(1'b1, 1'b1, 5'(i + 1), WD_MEM, 32'h0);
      in_dm_type = ty[i]; in_addr_lo = off[i];
      step();
      vecCnt++;
      if (rf_wd !== exp[i] || rf_wa !== 5'(i + 1) || rf_wr !== 1'b1) begin
        errCnt++; $display("FAIL load_%0d: wd=%h wa=%0d wr=%b want %h/%0d/1", i, rf_wd, rf_wa, rf_wr, exp[i], i + 1);
      end
    end
    setInstr(1'b1, 1'b1, 5'd20, WD_IMM, 32'h0);
    step();
    vecCnt++;
    if (rf_wd !== 32'h0000_0ABC) begin
      errCnt++; $display("FAIL imm_sel: wd=%h want 00000abc", rf_wd);
    end
    setInstr(1'b1, 1'b1, 5'd21, WD_PC4, 32'h0);
    step();
    vecCnt++;
    if (rf_wd !== 32'h0000_0104) begin
      errCnt++; $display("FAIL pc4_sel: wd=%h want 00000104", rf_wd);
    end
    checkRetire("load_cnt");
  endtask

  task automatic test_rd_zero();
    setInstr(1'b1, 1'b1, 5'd0, WD_ALU, 32'h5555_AAAA);
    step();
    vecCnt++;
    if (rf_wr !== 1'b0 || wb_valid !== 1'b1 || rf_wa !== 5'd0) begin
      errCnt++; $display("FAIL rd_zero: wr=%b valid=%b wa=%0d want 0/1/0", rf_wr, wb_valid, rf_wa);
    end
    checkRetire("rd_zero_cnt");
    setInstr(1'b0, 1'b1, 5'd3, WD_ALU, 32'h0000_0033);
    step();
    vecCnt++;
    if (rf_wr !== 1'b0 || wb_valid !== 1'b0 || rf_wa !== 5'd3) begin
      errCnt++; $display("FAIL invalid: wr=%b valid=%b wa=%0d want 0/0/3", rf_wr, wb_valid, rf_wa);
    end
    checkRetire("invalid_cnt");
  endtask

  task automatic test_stall_flush();
    setInstr(1'b1, 1'b1, 5'd7, WD_ALU, 32'hA5A5_0001);
    step();
    setInstr(1'b1, 1'b1, 5'd9, WD_ALU, 32'h0BAD_0BAD);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vecCnt++;
      if (rf_wr !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 32'hA5A5_0001 || wb_valid !== 1'b1) begin
        errCnt++; $display("FAIL stall_%0d: wr=%b wa=%0d wd=%h want 1/7/a5a50001", i, rf_wr, rf_wa, rf_wd);
      end
    end
    checkRetire("stall_cnt");
    flush = 1'b1;
    step();
    vecCnt++;
    if ({rf_wr, rf_wa, rf_wd, wb_valid} !== '0) begin
      errCnt++; $display("FAIL flush_stall: wr=%b wa=%0d wd=%h valid=%b want bubble", rf_wr, rf_wa, rf_wd, wb_valid);
    end
    checkRetire("flush_cnt");
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_async_reset();
    setInstr(1'b1, 1'b1, 5'd4, WD_ALU, 32'h0000_DEAD);
    step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    vecCnt++;
    if ({rf_wr, rf_wa, rf_wd, wb_valid} !== '0) begin
      errCnt++; $display("FAIL async_rst: wr=%b wa=%0d wd=%h valid=%b want all 0", rf_wr, rf_wa, rf_wd, wb_valid);
    end
    expRet = '0;
    checkRetire("async_rst_cnt");
    step();
    vecCnt++;
    if (rf_wr !== 1'b0 || wb_valid !== 1'b0) begin
      errCnt++; $display("FAIL rst_hold: wr=%b valid=%b want 0/0", rf_wr, wb_valid);
    end
    setInstr(1'b1, 1'b1, 5'd10, WD_PC4, 32'h0);
    in_pc4 = 32'h0000_0104;
    rst = 1'b0;
    step();
    vecCnt++;
    if (rf_wr !== 1'b1 || rf_wa !== 5'd10 || rf_wd !== 32'h0000_0104 || wb_valid !== 1'b1) begin
      errCnt++; $display("FAIL post_rst: wr=%b wa=%0d wd=%h want 1/10/00000104", rf_wr, rf_wa, rf_wd);
    end
  endtask

  task automatic test_retire_wrap();
`ifdef WB_RETIRE_CNT_EN
    @(negedge clk); rst = 1'b1; #1; rst = 1'b0; expRet = '0;
    for (int i = 0; i < 10; i++) begin
      setInstr(1'b1, 1'b1, 5'(i + 1), WD_ALU, 32'(i));
      step();
    end
    vecCnt++;
    if (retire_cnt !== 4'd10) begin
      errCnt++; $display("FAIL retire_10: got %0d want 10", retire_cnt);
    end
    for (int i = 0; i < 7; i++) step();
    vecCnt++;
    if (retire_cnt !== 4'd1) begin
      errCnt++; $display("FAIL retire_wrap: got %0d want 1", retire_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu_wb();
    test_load_ext();
    test_rd_zero();
    test_stall_flush();
    test_async_reset();
    test_retire_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
